// File: rtl/hw_interrupt_controller.sv
// Six-source interrupt controller: latches/masks device lines, drives CP0 HWInt[15:10],
// and provides CLAIM/COMPLETE handshaking with one level of nested service.
module hw_interrupt_controller #(
  parameter logic [5:0] EDGE_MASK = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  device_irq,
  input  logic [1:0]  addr,
  input  logic        rd_en,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [5:0]  interrupt_request
);

  localparam int unsigned N_SRC = 6;
  localparam int unsigned ID_W  = 3;

  localparam logic [1:0] A_PENDING  = 2'd0;
  localparam logic [1:0] A_MASK     = 2'd1;
  localparam logic [1:0] A_CLAIM    = 2'd2;
  localparam logic [1:0] A_COMPLETE = 2'd3;

  typedef enum logic {IDLE, SERVICE} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic              save_valid_q, save_valid_d;
  logic [ID_W-1:0]   save_id_q, save_id_d;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  mask_q, mask_d;
  logic [N_SRC-1:0]  irq_prev_q;

  logic [N_SRC-1:0]  allow, eligible, rise, clr, edge_next;
  logic [ID_W-1:0]   best_id;
  logic              best_valid, claim_ok, claim_fire, complete_fire;
  logic              unused_wdata;

  assign unused_wdata = ^wdata[31:N_SRC];

  // In SERVICE only strictly higher-priority (lower-index) sources pass.
  assign allow    = (state_q == IDLE) ? {N_SRC{1'b1}}
                                      : (N_SRC'(1) << cur_id_q) - N_SRC'(1);
  assign eligible = pending_q & mask_q & allow;
  assign interrupt_request = eligible;

  always_comb begin
    best_valid = 1'b0;
    best_id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        best_valid = 1'b1;
        best_id    = ID_W'(i);
      end
    end
  end

  // A nested claim needs the single save slot free.
  assign claim_ok      = best_valid && !(state_q == SERVICE && save_valid_q);
  assign claim_fire    = rd_en && (addr == A_CLAIM) && claim_ok;
  assign complete_fire = we && (addr == A_COMPLETE) && (state_q == SERVICE)
                         && (wdata[ID_W-1:0] == cur_id_q);

  assign rise      = device_irq & ~irq_prev_q;
  assign clr       = claim_fire ? (N_SRC'(1) << best_id) : '0;
  assign edge_next = (pending_q & ~clr) | rise;

  always_comb begin
    case (addr)
      A_PENDING: rdata = {26'b0, pending_q};
      A_MASK:    rdata = {26'b0, mask_q};
      A_CLAIM:   rdata = claim_ok ? {29'b0, best_id} : 32'hFFFF_FFFF;
      default:   rdata = 32'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    save_valid_d = save_valid_q;
    save_id_d    = save_id_q;
    mask_d       = mask_q;
    pending_d    = (EDGE_MASK & edge_next) | (~EDGE_MASK & device_irq);

    if (we && addr == A_MASK) mask_d = wdata[N_SRC-1:0];

    // Saving an IDLE context is equivalent to leaving the slot empty.
    if (claim_fire) begin
      save_valid_d = (state_q == SERVICE);
      save_id_d    = cur_id_q;
      cur_id_d     = best_id;
      state_d      = SERVICE;
    end else if (complete_fire) begin
      if (save_valid_q) begin
        cur_id_d     = save_id_q;
        save_valid_d = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_id_q     <= '0;
      save_valid_q <= 1'b0;
      save_id_q    <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      irq_prev_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      save_valid_q <= save_valid_d;
      save_id_q    <= save_id_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      irq_prev_q   <= device_irq;
    end
  end

endmodule

// File: tb/tb_hw_interrupt_controller.sv
// Directed bench for hw_interrupt_controller: source 0 edge-triggered, others level.
module tb_hw_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  device_irq;
  logic [1:0]  addr;
  logic        rd_en;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  interrupt_request;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  hw_interrupt_controller #(.EDGE_MASK(6'b000001)) dut (
    .clk(clk), .reset(reset), .device_irq(device_irq), .addr(addr),
    .rd_en(rd_en), .we(we), .wdata(wdata), .rdata(rdata),
    .interrupt_request(interrupt_request)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_irq(input string tag, input logic [5:0] exp);
    check_eq(tag, 32'(interrupt_request), 32'(exp));
  endtask

  // Bus read: rdata checked mid-cycle, strobe held across one edge.
  task automatic bus_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr  = a;
    rd_en = 1'b1;
    #1;
    check_eq(tag, rdata, exp);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; device_irq = '0; addr = '0; rd_en = 1'b0; we = 1'b0; wdata = '0;
    tick(); tick();
    check_irq("reset_irq", 6'h00);
    bus_rd("reset_pending", 2'd0, 32'h0);
    bus_rd("reset_mask", 2'd1, 32'h0);
    bus_rd("reset_claim", 2'd2, NONE);
    reset = 1'b0;
    tick();

    // Level source 3
    bus_wr(2'd1, 32'hFFFF_FFFF);
    bus_rd("mask_upper_zero", 2'd1, 32'h3F);
    device_irq = 6'b001000;
    tick();
    check_irq("level_irq", 6'b001000);
    bus_rd("level_claim", 2'd2, 32'd3);
    check_irq("level_in_service", 6'b000000);
    bus_rd("level_pending_kept", 2'd0, 32'h08);
    bus_wr(2'd3, 32'd3);
    check_irq("level_after_complete", 6'b001000);
    device_irq = 6'b000000;
    tick();
    check_irq("level_dropped", 6'b000000);

    // Edge source 0, single-cycle pulse
    device_irq = 6'b000001;
    tick();
    device_irq = 6'b000000;
    check_irq("edge_irq", 6'b000001);
    tick();
    bus_rd("edge_latched", 2'd0, 32'h01);
    bus_rd("edge_claim", 2'd2, 32'd0);
    bus_rd("edge_cleared", 2'd0, 32'h00);
    bus_wr(2'd3, 32'd0);
    check_irq("edge_done", 6'b000000);

    // Priority between sources 4 and 1
    device_irq = 6'b010010;
    tick();
    check_irq("prio_irq", 6'b010010);
    bus_rd("prio_claim1", 2'd2, 32'd1);
    check_irq("prio_in_service1", 6'b000000);
    device_irq = 6'b010000;
    tick();
    bus_wr(2'd3, 32'd1);
    check_irq("prio_after_complete1", 6'b010000);
    bus_rd("prio_claim4", 2'd2, 32'd4);
    check_irq("svc4_blocks_self", 6'b000000);

    // Nesting under source 4
    device_irq = 6'b010100;
    tick();
    check_irq("nest_irq2", 6'b000100);
    bus_rd("nest_claim2", 2'd2, 32'd2);
    check_irq("nest_in_service2", 6'b000000);
    device_irq = 6'b010101;
    tick();
    device_irq = 6'b010100;
    check_irq("nest_irq0", 6'b000001);
    bus_rd("nest_slot_full", 2'd2, NONE);
    check_irq("nest_unchanged", 6'b000001);
    bus_rd("nest_pending_kept", 2'd0, 32'h15);
    bus_wr(2'd3, 32'd4);
    check_irq("bad_complete_ignored", 6'b000001);
    bus_wr(2'd3, 32'd2);
    check_irq("restore_cur4", 6'b000101);
    bus_wr(2'd3, 32'd4);
    check_irq("back_to_idle", 6'b010101);
    bus_rd("idle_claim0", 2'd2, 32'd0);
    bus_wr(2'd3, 32'd0);
    check_irq("idle_after_claim0", 6'b010100);

    // Masking everything off
    device_irq = 6'b111111;
    tick();
    bus_wr(2'd1, 32'h0);
    check_irq("masked_irq", 6'b000000);
    bus_rd("masked_claim", 2'd2, NONE);
    bus_rd("masked_pending", 2'd0, 32'h3F);
    bus_wr(2'd3, 32'd0);
    check_irq("idle_complete_ignored", 6'b000000);
    bus_wr(2'd0, 32'h0);
    bus_rd("pending_write_ignored", 2'd0, 32'h3F);
    bus_wr(2'd1, 32'h3F);
    check_irq("unmasked_all", 6'b111111);
    bus_rd("all_claim0", 2'd2, 32'd0);
    check_irq("svc0_blocks_all", 6'b000000);
    bus_rd("edge0_cleared_level_kept", 2'd0, 32'h3E);

    // Mid-service reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_irq("mid_reset_irq", 6'b000000);
    bus_rd("mid_reset_pending", 2'd0, 32'h0);
    bus_rd("mid_reset_mask", 2'd1, 32'h0);
    check_irq("mid_reset_irq_later", 6'b000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hw_interrupt_controller.md
# hw_interrupt_controller

Collects the six external device interrupt lines, latches and masks them, and drives the `interrupt_request[15:10]` vector into the CP0 submission logic. The handler reads a memory-mapped CLAIM register to get the source ID and writes COMPLETE to retire it. A one-level in-service state machine ensures that, while a source is being serviced, only strictly higher-priority sources reach CP0. The block sits on the system bridge alongside the timers.

## Interface
- `EDGE_MASK`, default `6'b000000`: per-source trigger mode. Bit i=1 makes source i rising-edge triggered; bit i=0 makes it level triggered.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `device_irq`  in  6  raw device lines; bit i maps to HWInt `10+i`.
- `addr`  in  2  register select, word address [3:2]:
  - 0 = PENDING (RO)
  - 1 = MASK (RW)
  - 2 = CLAIM (RO, read has side effects)
  - 3 = COMPLETE (WO)
- `rd_en`  in  1  bus read strobe; qualifies CLAIM side effects.
- `we`  in  1  bus write strobe.
- `wdata`  in  32  bus write data.
- `rdata`  out  32  combinational read data for `addr`.
- `interrupt_request`  out  6  to CP0 `interrupt_request[15:10]`.

## Operation
- **Priority:** lower index = higher priority (source 0 highest).
- **Sampling:** `irq_prev <= device_irq` every cycle.
- **Pending update, edge source:** `pending[i]` sets on `device_irq[i] & ~irq_prev[i]`. It stays set until cleared by a CLAIM of source i.
- **Pending update, level source:** `pending[i] <= device_irq[i]` every cycle. CLAIM has no clearing effect on it.
- **MASK:** 6 bits, `wdata[5:0]`; upper bits read 0.
- **Eligible set:** `pending & mask & allow`.
  - `allow` = all ones in IDLE.
  - `allow` = sources with index < `cur_id` in SERVICE.
- **interrupt_request** = eligible set, combinational from registers.
- **best_id** = lowest-index bit of the eligible set. "None" when the set is empty.
- **State machine:**
  - IDLE → SERVICE on a CLAIM read (`rd_en & addr==2`) with best_id ≠ none.
    - Action: `cur_id <= best_id`, push the old `{state, cur_id}` into a one-entry save slot, clear the edge pending bit of best_id.
  - SERVICE → SERVICE (nested) on a CLAIM read with best_id ≠ none. Only allowed when the save slot is empty.
    - Action: save `{SERVICE, cur_id}` and take the new ID.
    - If the slot is full, the CLAIM returns none and changes nothing.
  - Any state, `we & addr==3` with `wdata[2:0]==cur_id`: restore from the save slot if it is full (slot then empties), else go to IDLE.
  - COMPLETE with a mismatching ID, or in IDLE: ignored.
- **Read data:**
  - PENDING: `{26'b0, pending}`.
  - MASK: `{26'b0, mask}`.
  - CLAIM: `{29'b0, best_id}`, or `32'hFFFF_FFFF` when none.
  - COMPLETE: reads 0.
- **Ignored accesses:** writes to PENDING and CLAIM.
- **Simultaneous events:**
  - New rising edge on source i in the same cycle as a CLAIM of i: set wins, so pending[i] stays 1.
  - MASK write concurrent with CLAIM: the CLAIM uses the old mask.
  - CLAIM and COMPLETE cannot coincide (single bus).

## Timing
- **Reset values:**
  - pending = 0, mask = 0, irq_prev = 0.
  - state = IDLE, cur_id = 0, save slot empty.
  - `interrupt_request` = 0.
  - `rdata` follows `addr` with reset register contents.
- **Latency:** `device_irq` first sampled high at edge n → pending set at edge n → `interrupt_request` asserted in cycle n+1 (if masked in).
- **CLAIM:** `rdata` is valid in the same cycle as `rd_en`. State, cur_id and pending update at the closing edge. `interrupt_request` reflects the new `allow` the next cycle.
- **COMPLETE:** takes effect at the write edge; `interrupt_request` updates the next cycle.
- **Mid-operation reset:** reset asserted in any state returns all state to the reset values at that edge. Pending edges are lost.

## Test plan
- **Reset, then level source:** mask=`6'h3F`, `device_irq[3]` held 1. Expect `interrupt_request=6'b001000` one cycle later, CLAIM returns 3, and `interrupt_request` returns 0 while in SERVICE with cur_id=3.
- **Edge source** (`EDGE_MASK=6'b000001`): 1-cycle pulse on bit 0. Expect pending[0] latched, CLAIM returns 0, and PENDING reads 0 afterwards.
- **Priority:** sources 4 and 1 pending together. Expect CLAIM=1. After COMPLETE(1), CLAIM=4.
- **Nesting:**
  - Claim 4, then source 2 rises: expect `interrupt_request=6'b000100`.
  - CLAIM returns 2, COMPLETE(2) restores cur_id=4, COMPLETE(4) returns to IDLE.
  - A third-level CLAIM while the slot is full returns `32'hFFFF_FFFF`.
- **Masking and bad accesses:** mask=0 with all sources pending: expect `interrupt_request=0` and CLAIM `32'hFFFF_FFFF`. COMPLETE with a wrong ID leaves state unchanged.
- **Mid-service reset:** reset asserted while in SERVICE clears state, pending and mask, and `interrupt_request` reads 0 the next cycle.
